// File: rtl/add_seq_ctrl_if.sv
// Requester handshake, result and shared-CLA signal bundle for add_seq_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface add_seq_ctrl_if;
  logic        REQ0, REQ1;
  logic [15:0] A0, A1, B0, B1;
  logic        SUB0, SUB1;
  logic        GNT0, GNT1;
  logic        BUSY, DONE, DONE_ID;
  logic [15:0] RESULT;
  logic        OVFL;
  logic [3:0]  CLA_A, CLA_B;
  logic        CLA_CIN;
  logic [3:0]  CLA_SUM;
  logic        CLA_COUT, CLA_OVFL;

  modport slave (
    input  REQ0, REQ1, A0, A1, B0, B1, SUB0, SUB1, CLA_SUM, CLA_COUT, CLA_OVFL,
    output GNT0, GNT1, BUSY, DONE, DONE_ID, RESULT, OVFL, CLA_A, CLA_B, CLA_CIN
  );

  modport master (
    output REQ0, REQ1, A0, A1, B0, B1, SUB0, SUB1, CLA_SUM, CLA_COUT, CLA_OVFL,
    input  GNT0, GNT1, BUSY, DONE, DONE_ID, RESULT, OVFL, CLA_A, CLA_B, CLA_CIN
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Two-requester 16-bit add/sub sequencer that time-shares an external 4-bit CLA,
// one nibble per cycle, with optional signed saturation of the final result.
module add_seq_ctrl #(
  parameter bit SAT = 1'b1
) (
  input logic           clk,
  input logic           rst,
  add_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  nib_q;
  logic        carry_q;
  logic        id_q;
  logic        last_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic [11:0] sum_q;
  logic [15:0] result_q;
  logic        ovfl_q;
  logic        done_id_q;

  logic        idle;
  logic        pick1;
  logic        gnt0;
  logic        gnt1;
  logic [15:0] a_sel, b_sel;
  logic        sub_sel;
  logic [15:0] sum_full_d;
  logic [15:0] result_d;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign idle  = (state_q == S_IDLE);
  assign pick1 = bus.REQ1 & (~bus.REQ0 | ~last_q);
  assign gnt0  = idle & ~rst & bus.REQ0 & ~pick1;
  assign gnt1  = idle & ~rst & pick1;

  assign a_sel   = gnt1 ? bus.A1   : bus.A0;
  assign b_sel   = gnt1 ? bus.B1   : bus.B0;
  assign sub_sel = gnt1 ? bus.SUB1 : bus.SUB0;

  assign sum_full_d = {bus.CLA_SUM, sum_q};
  assign result_d   = (SAT && bus.CLA_OVFL) ? (opa_q[15] ? 16'h8000 : 16'h7FFF)
                                            : sum_full_d;

  always_comb begin
    bus.CLA_A   = 4'h0;
    bus.CLA_B   = 4'h0;
    bus.CLA_CIN = 1'b0;
    if (state_q == S_RUN) begin
      bus.CLA_A   = opa_q[{nib_q, 2'b00} +: 4];
      bus.CLA_B   = opb_q[{nib_q, 2'b00} +: 4];
      bus.CLA_CIN = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nib_q     <= 2'd0;
      carry_q   <= 1'b0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      opa_q     <= 16'h0000;
      opb_q     <= 16'h0000;
      sum_q     <= 12'h000;
      result_q  <= 16'h0000;
      ovfl_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt0 | gnt1) begin
            opa_q   <= a_sel;
            opb_q   <= sub_sel ? ~b_sel : b_sel;
            carry_q <= sub_sel;
            id_q    <= gnt1;
            last_q  <= gnt1;
            nib_q   <= 2'd0;
            sum_q   <= 12'h000;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q <= bus.CLA_COUT;
          nib_q   <= nib_q + 2'd1;
          case (nib_q)
            2'd0: sum_q[3:0]  <= bus.CLA_SUM;
            2'd1: sum_q[7:4]  <= bus.CLA_SUM;
            2'd2: sum_q[11:8] <= bus.CLA_SUM;
            default: begin
              // Top nibble goes straight into the result; its carry-out is dropped.
              result_q  <= result_d;
              ovfl_q    <= bus.CLA_OVFL;
              done_id_q <= id_q;
              state_q   <= S_DONE;
            end
          endcase
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.GNT0    = gnt0;
  assign bus.GNT1    = gnt1;
  assign bus.BUSY    = (state_q != S_IDLE);
  assign bus.DONE    = (state_q == S_DONE);
  assign bus.DONE_ID = done_id_q;
  assign bus.RESULT  = result_q;
  assign bus.OVFL    = ovfl_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: saturating and wrapping instances run side by side
// against a behavioural 4-bit CLA, with a scoreboard of expected completions.
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = 16'h0, a1 = 16'h0, b0 = 16'h0, b1 = 16'h0;
  logic        sub0 = 1'b0, sub1 = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_seq_ctrl_if bus1 ();
  add_seq_ctrl_if bus0 ();

  add_seq_ctrl #(.SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  add_seq_ctrl #(.SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus1.REQ0 = req0;  assign bus0.REQ0 = req0;
  assign bus1.REQ1 = req1;  assign bus0.REQ1 = req1;
  assign bus1.A0   = a0;    assign bus0.A0   = a0;
  assign bus1.A1   = a1;    assign bus0.A1   = a1;
  assign bus1.B0   = b0;    assign bus0.B0   = b0;
  assign bus1.B1   = b1;    assign bus0.B1   = b1;
  assign bus1.SUB0 = sub0;  assign bus0.SUB0 = sub0;
  assign bus1.SUB1 = sub1;  assign bus0.SUB1 = sub1;

  // Behavioural shared CLA for each instance.
  assign {bus1.CLA_COUT, bus1.CLA_SUM} = {1'b0, bus1.CLA_A} + {1'b0, bus1.CLA_B} + {4'h0, bus1.CLA_CIN};
  assign bus1.CLA_OVFL = (bus1.CLA_A[3] == bus1.CLA_B[3]) && (bus1.CLA_SUM[3] != bus1.CLA_A[3]);
  assign {bus0.CLA_COUT, bus0.CLA_SUM} = {1'b0, bus0.CLA_A} + {1'b0, bus0.CLA_B} + {4'h0, bus0.CLA_CIN};
  assign bus0.CLA_OVFL = (bus0.CLA_A[3] == bus0.CLA_B[3]) && (bus0.CLA_SUM[3] != bus0.CLA_A[3]);

  typedef struct {
    logic        id;
    logic [15:0] rs;
    logic [15:0] rw;
    logic        ov;
    int          gc;
  } exp_t;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] rs;
    logic [15:0] rw;
    logic        ov;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic cin_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus1.DONE) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", bus1.DONE, 1'b0);
      end else begin
        mon_e = sbq.pop_front();
        chk("result_sat",  bus1.RESULT,  mon_e.rs);
        chk("result_wrap", bus0.RESULT,  mon_e.rw);
        chk("ovfl_sat",    bus1.OVFL,    mon_e.ov);
        chk("ovfl_wrap",   bus0.OVFL,    mon_e.ov);
        chk("done_id",     bus1.DONE_ID, mon_e.id);
        chk("done_wrap",   bus0.DONE,    1'b1);
        chk("latency",     cyc - mon_e.gc, 5);
      end
    end
    if (bus1.BUSY) cin_hist.push_back(bus1.CLA_CIN);
  end

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = !bus1.BUSY;
    end
    chk("idle_reached", seen, 1'b1);
  endtask

  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [15:0] rs, input logic [15:0] rw,
                       input logic ov);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = sub; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; sub0 = sub; end
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (id ? bus1.GNT1 : bus1.GNT0) begin
        got = 1'b1;
        chk("gnt_exclusive", id ? bus1.GNT0 : bus1.GNT1, 1'b0);
        sbq.push_back('{id, rs, rw, ov, cyc});
      end
    end
    chk("grant_seen", got, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    int   g0, g1;
    logic got;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 16'h2201, 1'b0};
    vecs[1] = '{1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b1};
    vecs[3] = '{1'b0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h7FFF, 1'b1};
    vecs[4] = '{1'b1, 16'h4000, 16'h4000, 1'b0, 16'h7FFF, 16'h8000, 1'b1};
    vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 16'h0FFF, 1'b0};
    vecs[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0};
    vecs[8] = '{1'b0, 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
    vecs[9] = '{1'b1, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 16'h8000, 1'b1};

    do_reset();

    @(negedge clk);
    chk("rst_busy",    bus1.BUSY,    1'b0);
    chk("rst_done",    bus1.DONE,    1'b0);
    chk("rst_result",  bus1.RESULT,  16'h0000);
    chk("rst_ovfl",    bus1.OVFL,    1'b0);
    chk("rst_done_id", bus1.DONE_ID, 1'b0);
    chk("rst_cla",     {bus1.CLA_A, bus1.CLA_B, bus1.CLA_CIN}, 9'h000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_quiet", {bus1.GNT0, bus1.GNT1, bus1.BUSY, bus1.DONE}, 4'h0);
    end

    // Carry ripple between nibbles: 0x00FF + 1.
    cin_hist.delete();
    do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0);
    chk("cin_count", cin_hist.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("cin_seq", (i < cin_hist.size()) ? cin_hist[i] : 1'bx, (i == 1 || i == 2) ? 1'b1 : 1'b0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].rs, vecs[i].rw, vecs[i].ov);

    // Both requesters waiting from reset release: round-robin and ignored REQ while busy.
    req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; sub0 = 1'b0;
    req1 = 1'b1; a1 = 16'h0010; b1 = 16'h0020; sub1 = 1'b0;
    do_reset();
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < 20 && g1 < 0; k++) begin
      @(negedge clk);
      if (bus1.GNT0 && g0 < 0) begin g0 = k; sbq.push_back('{1'b0, 16'h0003, 16'h0003, 1'b0, cyc}); end
      if (bus1.GNT1 && g1 < 0) begin g1 = k; sbq.push_back('{1'b1, 16'h0030, 16'h0030, 1'b0, cyc}); end
      @(posedge clk); #1;
      if (g0 == k) req0 = 1'b0;
      if (g1 == k) req1 = 1'b0;
    end
    chk("rr_gnt0_cycle", g0, 0);
    chk("rr_gnt1_cycle", g1, 6);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();

    // Reset while NIB = 2 aborts the operation.
    @(posedge clk); #1;
    a0 = 16'h0C84; b0 = 16'h0000; sub0 = 1'b0; req0 = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = bus1.GNT0;
    end
    chk("abort_grant", got, 1'b1);
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk); chk("abort_nib0", bus1.CLA_A, 4'h4);
    @(negedge clk); chk("abort_nib1", bus1.CLA_A, 4'h8);
    @(negedge clk); chk("abort_nib2", bus1.CLA_A, 4'hC);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy",   bus1.BUSY,   1'b0);
    chk("abort_result", bus1.RESULT, 16'h0000);
    chk("abort_wrap",   bus0.RESULT, 16'h0000);
    chk("abort_done",   bus1.DONE,   1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_done", bus1.DONE, 1'b0);
    end

    do_op(1'b1, 16'h1234, 16'h0234, 1'b1, 16'h1000, 16'h1000, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter SAT, default 1, meaning saturate RESULT on signed overflow (1) or wrap (0).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports REQ0/REQ1  input  1 each  requester 0/1 operation request, held until granted.
REQ-005 SHALL have ports A0/A1, B0/B1  input  16 each  requester operands.
REQ-006 SHALL have ports SUB0/SUB1  input  1 each  1 = A-B, 0 = A+B.
REQ-007 SHALL have ports GNT0/GNT1  output  1 each  one-cycle accept pulse; operands sampled at the edge ending that cycle.
REQ-008 SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have port DONE_ID  output  1  index of the requester whose result is presented.
REQ-011 SHALL have ports RESULT  output  16 and OVFL  output  1  final sum and signed-overflow flag.
REQ-012 SHALL have ports CLA_A, CLA_B  output  4 each, and CLA_CIN  output  1  operand nibbles and carry-in to the shared 4-bit CLA.
REQ-013 SHALL have ports CLA_SUM  input  4, CLA_COUT  input  1, CLA_OVFL  input  1  combinational results returned from the shared CLA.

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE; RUN SHALL last exactly 4 cycles, with a 2-bit nibble index NIB counting 0..3.
REQ-015 In IDLE with any REQ high, the block SHALL grant exactly one requester by round-robin: the requester not served last wins a tie; the LAST register resets to 1, so requester 0 wins the first tie.
REQ-016 GNTx SHALL assert combinationally only in IDLE; REQs in RUN or DONE SHALL be ignored and produce no GNT.
REQ-017 On grant, the block SHALL latch opA = Ax, opB = SUBx ? ~Bx : Bx, carry = SUBx, and ID = x, then enter RUN with NIB = 0.
REQ-018 In RUN, the block SHALL drive CLA_A = opA[4*NIB+3:4*NIB], CLA_B = opB nibble NIB, and CLA_CIN = carry.
REQ-019 At each RUN edge, the block SHALL write CLA_SUM into sum nibble NIB and load carry <= CLA_COUT.
REQ-020 At the NIB = 3 edge, the block SHALL also capture CLA_OVFL, then enter DONE.
REQ-021 In IDLE and DONE, CLA_A, CLA_B and CLA_CIN SHALL all be driven to 0.
REQ-022 In DONE, DONE = 1 for exactly one cycle, DONE_ID = ID, OVFL = captured overflow, and RESULT SHALL be registered.
REQ-023 If SAT = 1 and overflow is set, RESULT SHALL be 0x7FFF when opA[15] = 0, else 0x8000; otherwise RESULT SHALL equal the assembled sum.
REQ-024 RESULT, OVFL and DONE_ID SHALL hold their values until the next DONE.
REQ-025 Latency SHALL be fixed: grant in cycle T gives DONE in cycle T+5 and IDLE in T+6; the earliest next grant is T+6.
REQ-026 With no REQ in IDLE, the block SHALL remain in IDLE with all pulses low.
REQ-027 Arithmetic SHALL be 16-bit two's complement; the final carry-out is discarded and OVFL reflects signed overflow only.

Reset
REQ-028 While rst is high at a clock edge, the next state SHALL be IDLE, NIB = 0, carry = 0, RESULT = 0x0000, OVFL = 0, DONE_ID = 0, LAST = 1, and DONE, GNT0, GNT1 and BUSY SHALL be 0; this applies in any state.
REQ-029 Reset during RUN or DONE SHALL abort the operation: no DONE pulse for it, and partial sum discarded.

Verification
REQ-030 REQ0, A0 = 0x1234, B0 = 0x0FCD, SUB0 = 0 -> GNT0 at T, DONE at T+5, RESULT = 0x2201, OVFL = 0, DONE_ID = 0.
REQ-031 A0 = 0x00FF, B0 = 0x0001, add -> CLA_CIN over cycles T+1..T+4 = 0,1,1,0; RESULT = 0x0100.
REQ-032 SUB0 = 1, A0 = 0x0005, B0 = 0x0007 -> RESULT = 0xFFFE, OVFL = 0.
REQ-033 0x7FFF + 0x0001 -> OVFL = 1; RESULT = 0x7FFF when SAT = 1, 0x8000 when SAT = 0. Also 0x8000 - 0x0001 with SAT = 1 -> RESULT = 0x8000, OVFL = 1.
REQ-034 REQ0 and REQ1 both high from reset release -> GNT0 at T, GNT1 at T+6; DONE_ID = 0 at T+5 and 1 at T+11; a REQ1 held through T+1..T+5 produces no early GNT.
REQ-035 rst pulsed in RUN with NIB = 2 -> next cycle BUSY = 0, RESULT = 0x0000, and no DONE; a subsequent lone REQ1 is granted and completes normally.
